// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus program-load write port of the
// instruction memory responder.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid, req_addr, rsp_ready, load_we, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, load_we, load_addr, load_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency fetch with wait states and a
// program-load write port; storage survives reset.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h00400000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    imem_responder_if.slave bus
);
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_instr_q;
    logic        rsp_fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] fetch_addr;
    logic [31:0] fetch_off;
    logic        fetch_ok;
    logic [31:0] load_off;
    logic        load_ok;

    // Offset compare handles BASE_ADDR + span wrapping past 2^32.
    always_comb begin
        fetch_addr = (state == IDLE) ? bus.req_addr : addr_q;
        fetch_off  = fetch_addr - BASE_ADDR;
        fetch_ok   = (fetch_addr >= BASE_ADDR) && (fetch_off < SPAN_BYTES) &&
                     (fetch_addr[1:0] == 2'b00);
        load_off   = bus.load_addr - BASE_ADDR;
        load_ok    = (bus.load_addr >= BASE_ADDR) && (load_off < SPAN_BYTES) &&
                     (bus.load_addr[1:0] == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.load_we && load_ok) begin
            mem[IDX_W'(load_off >> 2)] <= bus.load_data;
        end
    end

    // Capture reads mem with <= so a same-edge load lands after the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        addr_q      <= bus.req_addr;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_instr_q <= fetch_ok ? mem[IDX_W'(fetch_off >> 2)] : 32'hDEADBEEF;
                            rsp_fault_q <= !fetch_ok;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_instr_q <= fetch_ok ? mem[IDX_W'(fetch_off >> 2)] : 32'hDEADBEEF;
                        rsp_fault_q <= !fetch_ok;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: instance A with two wait states, instance B with none,
// sharing clock and reset.
module tb_imem_responder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    imem_responder_if ifa ();
    imem_responder_if ifb ();

    imem_responder #(.BASE_ADDR(32'h00400000), .DEPTH_WORDS(1024), .WAIT_CYCLES(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    imem_responder #(.BASE_ADDR(32'h00400000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [31:0] addr, input logic [31:0] data);
        ifa.load_we = 1'b1; ifa.load_addr = addr; ifa.load_data = data;
        step(1);
        ifa.load_we = 1'b0;
    endtask

    task automatic load_b(input logic [31:0] addr, input logic [31:0] data);
        ifb.load_we = 1'b1; ifb.load_addr = addr; ifb.load_data = data;
        step(1);
        ifb.load_we = 1'b0;
    endtask

    // Full fetch on A with continuous rsp_ready; response expected after the
    // second edge following accept (sampled valid at accept+3).
    task automatic fetch_a(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_i, input logic exp_f);
        ifa.req_valid = 1'b1; ifa.req_addr = addr; ifa.rsp_ready = 1'b1;
        chk({tag, "_idle_ready"}, 32'(ifa.req_ready), 32'd1);
        step(1);
        ifa.req_valid = 1'b0; ifa.req_addr = 32'h0;
        chk({tag, "_wait_ready"}, 32'(ifa.req_ready), 32'd0);
        chk({tag, "_wait_valid0"}, 32'(ifa.rsp_valid), 32'd0);
        step(1);
        chk({tag, "_wait_valid1"}, 32'(ifa.rsp_valid), 32'd0);
        step(1);
        chk({tag, "_rsp_valid"}, 32'(ifa.rsp_valid), 32'd1);
        chk({tag, "_rsp_instr"}, ifa.rsp_instr, exp_i);
        chk({tag, "_rsp_fault"}, 32'(ifa.rsp_fault), 32'(exp_f));
        step(1);
        chk({tag, "_post_valid"}, 32'(ifa.rsp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(ifa.req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.rsp_ready = 1'b0;
        ifa.load_we = 1'b0; ifa.load_addr = '0; ifa.load_data = '0;
        ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.rsp_ready = 1'b0;
        ifb.load_we = 1'b0; ifb.load_addr = '0; ifb.load_data = '0;
        step(2);
        chk("reset_ready", 32'(ifa.req_ready), 32'd1);
        chk("reset_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("reset_instr", ifa.rsp_instr, 32'h0);
        chk("reset_fault", 32'(ifa.rsp_fault), 32'd0);
        chk("reset_b_ready", 32'(ifb.req_ready), 32'd1);
        rst = 1'b0;

        load_a(32'h00400000, 32'h00500093);
        load_a(32'h00400FFC, 32'hABCD1234);
        load_a(32'h00400008, 32'hCAFE0001);
        load_b(32'h00400000, 32'h00500093);
        load_b(32'h00400004, 32'h00000013);

        // Basic in-range fetch and address-decode boundaries
        fetch_a("word0", 32'h00400000, 32'h00500093, 1'b0);
        fetch_a("lastword", 32'h00400FFC, 32'hABCD1234, 1'b0);
        fetch_a("misaligned", 32'h00400002, 32'hDEADBEEF, 1'b1);
        fetch_a("zero", 32'h00000000, 32'hDEADBEEF, 1'b1);
        fetch_a("past_end", 32'h00401000, 32'hDEADBEEF, 1'b1);
        fetch_a("below_base", 32'h003FFFFC, 32'hDEADBEEF, 1'b1);

        // Back-pressure in RESP with request-side noise
        ifa.req_valid = 1'b1; ifa.req_addr = 32'h00400008; ifa.rsp_ready = 1'b0;
        step(1);
        ifa.req_valid = 1'b0;
        step(2);
        chk("hold_valid", 32'(ifa.rsp_valid), 32'd1);
        chk("hold_instr", ifa.rsp_instr, 32'hCAFE0001);
        for (int i = 0; i < 5; i++) begin
            ifa.req_valid = ~ifa.req_valid;
            ifa.req_addr = 32'h00400000 + 32'(i * 4);
            step(1);
            chk("hold_cyc_valid", 32'(ifa.rsp_valid), 32'd1);
            chk("hold_cyc_ready", 32'(ifa.req_ready), 32'd0);
            chk("hold_cyc_instr", ifa.rsp_instr, 32'hCAFE0001);
            chk("hold_cyc_fault", 32'(ifa.rsp_fault), 32'd0);
        end
        ifa.req_valid = 1'b0; ifa.rsp_ready = 1'b1;
        step(1);
        chk("hold_done_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("hold_done_ready", 32'(ifa.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("hold_single_rsp", 32'(ifa.rsp_valid), 32'd0);
        end

        // Zero wait states: response one cycle after accept, one every two cycles
        ifb.req_valid = 1'b1; ifb.req_addr = 32'h00400000; ifb.rsp_ready = 1'b1;
        chk("w0_idle_ready", 32'(ifb.req_ready), 32'd1);
        step(1);
        chk("w0_rsp1_valid", 32'(ifb.rsp_valid), 32'd1);
        chk("w0_rsp1_instr", ifb.rsp_instr, 32'h00500093);
        chk("w0_rsp1_fault", 32'(ifb.rsp_fault), 32'd0);
        chk("w0_rsp1_ready", 32'(ifb.req_ready), 32'd0);
        ifb.req_addr = 32'h00400004;
        step(1);
        chk("w0_gap_valid", 32'(ifb.rsp_valid), 32'd0);
        chk("w0_gap_ready", 32'(ifb.req_ready), 32'd1);
        step(1);
        chk("w0_rsp2_valid", 32'(ifb.rsp_valid), 32'd1);
        chk("w0_rsp2_instr", ifb.rsp_instr, 32'h00000013);
        ifb.req_valid = 1'b0;
        step(1);
        chk("w0_end_valid", 32'(ifb.rsp_valid), 32'd0);
        chk("w0_end_ready", 32'(ifb.req_ready), 32'd1);

        // Load during WAIT is visible in the response
        load_a(32'h00400004, 32'h11111111);
        ifa.req_valid = 1'b1; ifa.req_addr = 32'h00400004; ifa.rsp_ready = 1'b1;
        step(1);
        ifa.req_valid = 1'b0;
        ifa.load_we = 1'b1; ifa.load_addr = 32'h00400004; ifa.load_data = 32'h22222222;
        step(1);
        ifa.load_we = 1'b0;
        step(1);
        chk("ldwait_valid", 32'(ifa.rsp_valid), 32'd1);
        chk("ldwait_instr", ifa.rsp_instr, 32'h22222222);
        step(1);

        // Load on the capture edge returns the old word
        load_a(32'h00400004, 32'h11111111);
        ifa.req_valid = 1'b1; ifa.req_addr = 32'h00400004;
        step(1);
        ifa.req_valid = 1'b0;
        step(1);
        ifa.load_we = 1'b1; ifa.load_addr = 32'h00400004; ifa.load_data = 32'h22222222;
        step(1);
        ifa.load_we = 1'b0;
        chk("ldcap_valid", 32'(ifa.rsp_valid), 32'd1);
        chk("ldcap_instr", ifa.rsp_instr, 32'h11111111);
        step(1);
        fetch_a("ldcap_after", 32'h00400004, 32'h22222222, 1'b0);

        // Misaligned load must not touch word 0
        load_a(32'h00400002, 32'hFFFFFFFF);

        // Reset during WAIT, with a load attempted under reset
        ifa.req_valid = 1'b1; ifa.req_addr = 32'h00400000;
        step(1);
        ifa.req_valid = 1'b0;
        rst = 1'b1;
        ifa.load_we = 1'b1; ifa.load_addr = 32'h00400000; ifa.load_data = 32'hBADBAD00;
        step(1);
        rst = 1'b0;
        ifa.load_we = 1'b0;
        chk("rstwait_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rstwait_ready", 32'(ifa.req_ready), 32'd1);
        chk("rstwait_instr", ifa.rsp_instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rstwait_no_rsp", 32'(ifa.rsp_valid), 32'd0);
        end
        fetch_a("after_rst", 32'h00400000, 32'h00500093, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00400000, giving the byte address of instruction word 0 (text segment).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit instruction words stored.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the wait states inserted before each response.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  block can accept a fetch request.
REQ-008 req_addr  input  32  byte address of the requested instruction (PC).
REQ-009 rsp_valid  output  1  response present on rsp_instr/rsp_fault.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_instr  output  32  fetched instruction word.
REQ-012 rsp_fault  output  1  request was misaligned or outside the stored range.
REQ-013 load_we  input  1  program-load write enable.
REQ-014 load_addr  input  32  byte address of the load write.
REQ-015 load_data  input  32  instruction word to store.

Function
REQ-016 Address decode: an address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS and addr[1:0] == 2'b00; word index = (addr - BASE_ADDR) >> 2.
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-018 Request accept: req_valid && req_ready at an edge; req_addr is latched on that edge.
REQ-019 On accept, if WAIT_CYCLES == 0 the FSM SHALL go IDLE->RESP; otherwise IDLE->WAIT with a down-counter loaded with WAIT_CYCLES.
REQ-020 In WAIT the counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL go WAIT->RESP.
REQ-021 Latency: rsp_valid SHALL first be high exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-022 rsp_instr and rsp_fault SHALL be registered on the edge that enters RESP, then held stable while rsp_valid=1 and rsp_ready=0.
REQ-023 On rsp_valid && rsp_ready at an edge the FSM SHALL go RESP->IDLE; a new request cannot be accepted in that same cycle (req_ready=0 in RESP).
REQ-024 In-range fetch: rsp_instr = stored word at the index, rsp_fault = 0.
REQ-025 Out-of-range or misaligned fetch: rsp_instr = 32'hDEADBEEF, rsp_fault = 1; the FSM timing is the same as for an in-range fetch.
REQ-026 Load: when load_we=1 and load_addr is in range, load_data SHALL be written to the addressed word at the edge; out-of-range or misaligned loads SHALL be ignored.
REQ-027 Loads SHALL be accepted in every state and do not affect the FSM.
REQ-028 Load and response-capture to the same word on the same edge: the response SHALL return the old word (read-before-write).
REQ-029 A load landing in WAIT before the capture edge SHALL be visible in that response.
REQ-030 req_addr changes while not in IDLE SHALL be ignored.
REQ-031 Contents of never-loaded words are unspecified.

Reset
REQ-032 While rst=1 at an edge: FSM -> IDLE, counter -> 0, rsp_instr -> 32'h00000000, rsp_fault -> 0; therefore req_ready=1 and rsp_valid=0 after the edge.
REQ-033 Reset mid-transaction (WAIT or RESP) SHALL abandon the transaction with no response issued.
REQ-034 Reset SHALL NOT clear the instruction storage; loaded programs survive reset.
REQ-035 The block SHALL ignore load_we while rst=1.

Verification
REQ-036 Load 0x00500093 at 0x00400000, WAIT_CYCLES=2, request 0x00400000 with rsp_ready=1 -> rsp_valid high 3 cycles after accept with instr 0x00500093, fault 0, and req_ready back to 1 the cycle after the handshake.
REQ-037 Request 0x00400002 -> instr 0xDEADBEEF, fault 1, same latency. Repeat with 0x00000000 and with 0x00401000 (DEPTH=1024) -> same result.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid/req_addr -> rsp_instr is stable, req_ready=0, and only one response is produced.
REQ-039 WAIT_CYCLES=0 -> rsp_valid is high 1 cycle after accept; back-to-back requests produce a response every 2 cycles with continuous rsp_ready.
REQ-040 Load 0x11111111 at 0x00400004, request that address, rewrite it with 0x22222222 during WAIT -> response is 0x22222222; rewriting it on the capture edge instead -> response is 0x11111111.
REQ-041 Assert rst for 1 cycle during WAIT -> no rsp_valid, req_ready=1; a subsequent request returns the previously loaded word (storage preserved).
